// File: rtl/pld_deseg.sv
// pld_deseg: receive-side payload de-segmenter.
// Packs the serial payload bit stream (LSB of each byte first) into bytes and
// discards the zero padding that rounds the payload up to a multiple of BLK_BITS.
// The recovered byte is presented on dout, qualified by do_vld.
module pld_deseg #(
  parameter int BLK_BITS = 512,
  parameter int LEN_W    = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] len,
  input  logic             len_vld,
  input  logic             di,
  input  logic             di_vld,
  output logic [7:0]       dout,
  output logic             do_vld,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam int PW = $clog2(BLK_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAD  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [PW-1:0]    pad_cnt_q, pad_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [6:0]       sreg_q, sreg_d;
  logic [7:0]       dout_q, dout_d;
  logic             do_vld_q, do_vld_d;
  logic             err_q, err_d;

  // Padding only depends on len*8 modulo the block size, i.e. on its low PW bits.
  logic [PW-1:0] len_bits_lo;
  logic [PW-1:0] pad_bits;
  logic          last_byte;
  logic          in_frame;

  assign len_bits_lo = PW'({len, 3'b000});
  assign pad_bits    = PW'(0) - len_bits_lo;
  assign last_byte   = (byte_cnt_q == len_q - LEN_W'(1));
  assign in_frame    = (state_q == DATA) || (state_q == PAD);

  // State register.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: a frame start always wins, even in the middle of a frame.
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch can be inferred.
  always_comb begin
    state_d = state_q;
    if (len_vld) begin
      state_d = (len == '0) ? FIN : DATA;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        DATA: if (di_vld && bit_cnt_q == 3'd7 && last_byte)
                state_d = (pad_cnt_q != '0) ? PAD : FIN;
        PAD:  if (di_vld && pad_cnt_q == PW'(1)) state_d = FIN;
        FIN:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: byte assembly, byte/pad counting and violation detection.
  always_comb begin
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    pad_cnt_d  = pad_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sreg_d     = sreg_q;
    dout_d     = dout_q;
    do_vld_d   = 1'b0;
    // Bits arriving outside a frame, or a new frame cutting into a running one.
    err_d      = (di_vld && !in_frame) || (len_vld && in_frame);

    if (len_vld) begin
      // Any bit in the frame-start cycle is dropped; a partial byte is discarded.
      len_d      = len;
      pad_cnt_d  = pad_bits;
      byte_cnt_d = '0;
      bit_cnt_d  = '0;
      sreg_d     = '0;
    end else if (di_vld) begin
      if (state_q == DATA) begin
        if (bit_cnt_q == 3'd7) begin
          dout_d     = {di, sreg_q};
          do_vld_d   = 1'b1;
          byte_cnt_d = byte_cnt_q + LEN_W'(1);
          bit_cnt_d  = '0;
        end else begin
          sreg_d[bit_cnt_q] = di;
          bit_cnt_d         = bit_cnt_q + 3'd1;
        end
      end else if (state_q == PAD) begin
        pad_cnt_d = pad_cnt_q - PW'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      byte_cnt_q <= '0;
      pad_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      sreg_q     <= '0;
      dout_q     <= '0;
      do_vld_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      pad_cnt_q  <= pad_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sreg_q     <= sreg_d;
      dout_q     <= dout_d;
      do_vld_q   <= do_vld_d;
      err_q      <= err_d;
    end
  end

  // Outputs: done and busy decode the state, the rest come straight from flops.
  always_comb begin
    busy   = in_frame;
    done   = (state_q == FIN);
    dout   = dout_q;
    do_vld = do_vld_q;
    err    = err_q;
  end

endmodule

// File: tb/tb_pld_deseg.sv
// tb_pld_deseg: directed bench for pld_deseg with a byte scoreboard.
module tb_pld_deseg;

  localparam int BLK = 512;
  localparam int LW  = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] len;
  logic          len_vld;
  logic          di;
  logic          di_vld;
  logic [7:0]    dout;
  logic          do_vld;
  logic          done;
  logic          busy;
  logic          err;

  pld_deseg #(.BLK_BITS(BLK), .LEN_W(LW)) dut (
    .clk     (clk),
    .rst     (rst),
    .len     (len),
    .len_vld (len_vld),
    .di      (di),
    .di_vld  (di_vld),
    .dout    (dout),
    .do_vld  (do_vld),
    .done    (done),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_dv, n_done, n_err, n_bits;
  int done_tick, err_tick, last_bit_tick, start_tick;
  bit gap_mode;
  bit done_with_vld;
  logic [7:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (do_vld === 1'b1) begin
      n_dv++;
      if (sb.size() == 0) check("unexpected_do_vld", 32'd1, 32'd0);
      else                check("byte", {24'd0, dout}, {24'd0, sb.pop_front()});
    end
    if (done === 1'b1) begin
      n_done++;
      done_tick = cyc;
      if (do_vld === 1'b1) done_with_vld = 1'b1;
    end
    if (err === 1'b1) begin
      n_err++;
      err_tick = cyc;
    end
  endtask

  task automatic clear();
    n_dv = 0; n_done = 0; n_err = 0; n_bits = 0;
    done_tick = -1; err_tick = -1; done_with_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int pad_of(input int l);
    return (BLK - ((l * 8) % BLK)) % BLK;
  endfunction

  task automatic put_bit(input logic b);
    di     = b;
    di_vld = 1'b1;
    tick();
    last_bit_tick = cyc;
    n_bits++;
    di_vld = 1'b0;
    if (gap_mode) tick();
  endtask

  task automatic start(input int l, input bit with_di);
    len     = LW'(l);
    len_vld = 1'b1;
    di      = 1'b1;
    di_vld  = with_di;
    tick();
    start_tick = cyc;
    len_vld = 1'b0;
    di_vld  = 1'b0;
  endtask

  task automatic send_bytes(input int n, input bit fixed_en, input logic [7:0] fv);
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      b = fixed_en ? fv : 8'($urandom_range(0, 255));
      for (int i = 0; i < 8; i++) begin
        if (i == 7) sb.push_back(b);
        put_bit(b[i]);
      end
    end
  endtask

  task automatic send_pad(input int n);
    for (int i = 0; i < n; i++) put_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic frame_end(input string tag, input int dv, input int dn, input int er);
    check({tag, "_do_vld_count"}, n_dv, dv);
    check({tag, "_done_count"}, n_done, dn);
    check({tag, "_err_count"}, n_err, er);
    check({tag, "_scoreboard_empty"}, sb.size(), 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_dout"}, {24'd0, dout}, 32'd0);
    check({tag, "_do_vld"}, {31'd0, do_vld}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; len = '0; len_vld = 1'b0; di = 1'b0; di_vld = 1'b0; gap_mode = 1'b0;
    clear();
    #2;
    check_quiet("reset");
    idle(2);
    rst = 1'b0;
    idle(2);

    // len=64: no padding, done together with the last byte.
    clear();
    start(64, 1'b0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    send_bytes(64, 1'b0, 8'h00);
    check("t1_done_tick", done_tick, last_bit_tick);
    check("t1_done_with_vld", {31'd0, done_with_vld}, 32'd1);
    idle(3);
    check("t1_busy_after", {31'd0, busy}, 32'd0);
    frame_end("t1", 64, 1, 0);

    // len=1: byte 0x05 then 504 pad bits.
    clear();
    start(1, 1'b0);
    send_bytes(1, 1'b1, 8'h05);
    check("t2_no_done_before_pad", n_done, 0);
    send_pad(pad_of(1));
    check("t2_done_tick", done_tick, last_bit_tick);
    check("t2_done_with_vld", {31'd0, done_with_vld}, 32'd0);
    idle(3);
    frame_end("t2", 1, 1, 0);

    // len=3 with di_vld toggling every cycle.
    clear();
    gap_mode = 1'b1;
    start(3, 1'b0);
    send_bytes(3, 1'b0, 8'h00);
    send_pad(pad_of(3));
    gap_mode = 1'b0;
    check("t3_valid_bits", n_bits, BLK);
    check("t3_done_tick", done_tick, last_bit_tick);
    idle(3);
    frame_end("t3", 3, 1, 0);

    // len=0: immediate done, busy never rises.
    clear();
    start(0, 1'b0);
    check("t4_done_tick", done_tick, start_tick);
    check("t4_busy", {31'd0, busy}, 32'd0);
    idle(3);
    frame_end("t4", 0, 1, 0);

    // Abort in PAD by a new len=2 frame.
    clear();
    start(5, 1'b0);
    send_bytes(5, 1'b0, 8'h00);
    send_pad(100);
    start(2, 1'b0);
    check("t5_err_tick", err_tick, start_tick);
    check("t5_no_done_first", n_done, 0);
    send_bytes(2, 1'b0, 8'h00);
    send_pad(pad_of(2));
    check("t5_done_tick", done_tick, last_bit_tick);
    idle(3);
    frame_end("t5", 7, 1, 1);

    // Stray bit in IDLE.
    clear();
    di = 1'b1; di_vld = 1'b1;
    tick();
    di_vld = 1'b0;
    check("t6_err_tick", err_tick, cyc);
    idle(3);
    frame_end("t6", 0, 0, 1);

    // len_vld together with di_vld in IDLE: frame starts, that bit is dropped.
    clear();
    start(1, 1'b1);
    check("t7_err_tick", err_tick, start_tick);
    send_bytes(1, 1'b0, 8'h00);
    send_pad(pad_of(1));
    idle(3);
    frame_end("t7", 1, 1, 1);

    // Reset in the middle of DATA, then a clean frame.
    clear();
    start(4, 1'b0);
    send_bytes(2, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) put_bit(1'b1);
    rst = 1'b1;
    #1;
    check_quiet("t8_mid_reset");
    idle(2);
    rst = 1'b0;
    idle(2);
    frame_end("t8_pre", 2, 0, 0);
    clear();
    start(2, 1'b0);
    send_bytes(2, 1'b0, 8'h00);
    send_pad(pad_of(2));
    check("t8_done_tick", done_tick, last_bit_tick);
    idle(3);
    frame_end("t8", 2, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
